// File: rtl/pipe_stage_regs.sv
// IF/ID, ID/EX and EX/MEM pipeline registers with stall, flush and
// deferred-flush handling plus a saturating bubble counter.
module pipe_stage_regs #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iStall_global,
  input  logic          iStall_dec,
  input  logic          iFlush_ifdec,
  input  logic          iFlush_decex,
  input  logic          iFlush_exmem,
  input  logic [AW-1:0] iPC_F,
  input  logic [DW-1:0] iInst_F,
  input  logic          iValid_F,
  input  logic [CW-1:0] iCtrl_D,
  input  logic [4:0]    iRt_D,
  output logic [AW-1:0] oPC_RegD,
  output logic [DW-1:0] oInst_RegD,
  output logic          oValid_RegD,
  output logic [AW-1:0] oPC_RegE,
  output logic [CW-1:0] oCtrl_RegE,
  output logic [4:0]    oRt_RegE,
  output logic          oValid_RegE,
  output logic [AW-1:0] oPC_RegM,
  output logic [CW-1:0] oCtrl_RegM,
  output logic          oValid_RegM,
  output logic [2:0]    oPendFlush,
  output logic [15:0]   oBubbleCnt
);

  logic [AW-1:0] r_pc_d;
  logic [DW-1:0] r_inst_d;
  logic          r_v_d;
  logic [AW-1:0] r_pc_e;
  logic [CW-1:0] r_ctrl_e;
  logic [4:0]    r_rt_e;
  logic          r_v_e;
  logic [AW-1:0] r_pc_m;
  logic [CW-1:0] r_ctrl_m;
  logic          r_v_m;
  logic [2:0]    r_pend;
  logic [15:0]   r_cnt;

  logic [2:0]    w_flush_in;
  logic [2:0]    w_flush;
  logic          w_bub_e;
  logic          w_cnt_sat;

  assign w_flush_in = {iFlush_exmem, iFlush_decex, iFlush_ifdec};
  assign w_flush    = w_flush_in | r_pend;
  assign w_bub_e    = w_flush[1] | iStall_dec;
  assign w_cnt_sat  = &r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_d   <= '0;
      r_inst_d <= '0;
      r_v_d    <= 1'b0;
      r_pc_e   <= '0;
      r_ctrl_e <= '0;
      r_rt_e   <= '0;
      r_v_e    <= 1'b0;
      r_pc_m   <= '0;
      r_ctrl_m <= '0;
      r_v_m    <= 1'b0;
      r_pend   <= '0;
      r_cnt    <= '0;
    end else if (iStall_global) begin
      // Frozen: remember flushes so they land on the release edge
      r_pend <= r_pend | w_flush_in;
    end else begin
      r_pend <= '0;
      // IF/ID: flush beats load-use hold
      if (w_flush[0]) begin
        r_pc_d   <= '0;
        r_inst_d <= '0;
        r_v_d    <= 1'b0;
      end else if (!iStall_dec) begin
        r_pc_d   <= iPC_F;
        r_inst_d <= iInst_F;
        r_v_d    <= iValid_F;
      end
      if (w_bub_e) begin
        r_pc_e   <= '0;
        r_ctrl_e <= '0;
        r_rt_e   <= '0;
        r_v_e    <= 1'b0;
      end else begin
        r_pc_e   <= r_pc_d;
        r_ctrl_e <= r_v_d ? iCtrl_D : '0;
        r_rt_e   <= iRt_D;
        r_v_e    <= r_v_d;
      end
      // EX/MEM ignores load-use stall so the load drains
      if (w_flush[2]) begin
        r_pc_m   <= '0;
        r_ctrl_m <= '0;
        r_v_m    <= 1'b0;
      end else begin
        r_pc_m   <= r_pc_e;
        r_ctrl_m <= r_ctrl_e;
        r_v_m    <= r_v_e;
      end
      if (w_bub_e && !w_cnt_sat) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign oPC_RegD    = r_pc_d;
  assign oInst_RegD  = r_inst_d;
  assign oValid_RegD = r_v_d;
  assign oPC_RegE    = r_pc_e;
  assign oCtrl_RegE  = r_ctrl_e;
  assign oRt_RegE    = r_rt_e;
  assign oValid_RegE = r_v_e;
  assign oPC_RegM    = r_pc_m;
  assign oCtrl_RegM  = r_ctrl_m;
  assign oValid_RegM = r_v_m;
  assign oPendFlush  = r_pend;
  assign oBubbleCnt  = r_cnt;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Self-checking bench for pipe_stage_regs: directed scenarios plus
// randomized traffic against a stage-level reference model.
module tb_pipe_stage_regs;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int VW = 187;

  logic          clk = 1'b0;
  logic          rst;
  logic          iStall_global, iStall_dec;
  logic          iFlush_ifdec, iFlush_decex, iFlush_exmem;
  logic [AW-1:0] iPC_F;
  logic [DW-1:0] iInst_F;
  logic          iValid_F;
  logic [CW-1:0] iCtrl_D;
  logic [4:0]    iRt_D;
  logic [AW-1:0] oPC_RegD, oPC_RegE, oPC_RegM;
  logic [DW-1:0] oInst_RegD;
  logic          oValid_RegD, oValid_RegE, oValid_RegM;
  logic [CW-1:0] oCtrl_RegE, oCtrl_RegM;
  logic [4:0]    oRt_RegE;
  logic [2:0]    oPendFlush;
  logic [15:0]   oBubbleCnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_regs #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .iStall_global(iStall_global), .iStall_dec(iStall_dec),
    .iFlush_ifdec(iFlush_ifdec), .iFlush_decex(iFlush_decex),
    .iFlush_exmem(iFlush_exmem),
    .iPC_F(iPC_F), .iInst_F(iInst_F), .iValid_F(iValid_F),
    .iCtrl_D(iCtrl_D), .iRt_D(iRt_D),
    .oPC_RegD(oPC_RegD), .oInst_RegD(oInst_RegD), .oValid_RegD(oValid_RegD),
    .oPC_RegE(oPC_RegE), .oCtrl_RegE(oCtrl_RegE), .oRt_RegE(oRt_RegE),
    .oValid_RegE(oValid_RegE),
    .oPC_RegM(oPC_RegM), .oCtrl_RegM(oCtrl_RegM), .oValid_RegM(oValid_RegM),
    .oPendFlush(oPendFlush), .oBubbleCnt(oBubbleCnt)
  );

  // Reference model: one record per pipeline slot
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
    logic [CW-1:0] ctrl;
    logic [4:0]    rt;
    logic          valid;
  } slot_t;

  slot_t      m_d, m_e, m_m;
  logic [2:0] m_pend;
  int         m_cnt;

  function automatic logic [VW-1:0] dut_vec();
    return {oPC_RegD, oInst_RegD, oValid_RegD,
            oPC_RegE, oCtrl_RegE, oRt_RegE, oValid_RegE,
            oPC_RegM, oCtrl_RegM, oValid_RegM,
            oPendFlush, oBubbleCnt};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {m_d.pc, m_d.inst, m_d.valid,
            m_e.pc, m_e.ctrl, m_e.rt, m_e.valid,
            m_m.pc, m_m.ctrl, m_m.valid,
            m_pend, m_cnt[15:0]};
  endfunction

  task automatic model_step();
    slot_t      nd, ne, nm;
    logic [2:0] fl;
    bit         bub;
    if (rst) begin
      m_d = '0; m_e = '0; m_m = '0; m_pend = '0; m_cnt = 0;
    end else if (iStall_global) begin
      m_pend = m_pend | {iFlush_exmem, iFlush_decex, iFlush_ifdec};
    end else begin
      fl  = {iFlush_exmem, iFlush_decex, iFlush_ifdec} | m_pend;
      bub = fl[1] || iStall_dec;
      nd  = m_d;
      if (fl[0]) nd = '0;
      else if (!iStall_dec) nd = '{iPC_F, iInst_F, '0, '0, iValid_F};
      ne = '0;
      if (!bub) ne = '{m_d.pc, '0, m_d.valid ? iCtrl_D : '0, iRt_D, m_d.valid};
      nm = fl[2] ? '0 : '{m_e.pc, '0, m_e.ctrl, '0, m_e.valid};
      m_d = nd; m_e = ne; m_m = nm;
      m_pend = '0;
      if (bub) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iStall_global = 0; iStall_dec = 0;
    iFlush_ifdec = 0; iFlush_decex = 0; iFlush_exmem = 0;
    iValid_F = 0; iPC_F = '0; iInst_F = '0; iCtrl_D = '0; iRt_D = '0;
  endtask

  task automatic feed(input logic [AW-1:0] pc);
    iPC_F = pc; iInst_F = 32'h8C00_0000 | pc; iValid_F = 1;
    iCtrl_D = 16'h00A5; iRt_D = 5'd9;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_zero: got %h expected 0", dut_vec());
    end
    feed(32'h40); tick();
    n_checks++;
    if (oPC_RegD !== 32'h40 || oValid_RegD !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_D: got pc %h v %b expected 40 1", oPC_RegD, oValid_RegD);
    end
    feed(32'h44); tick();
    n_checks++;
    if (oPC_RegE !== 32'h40 || oCtrl_RegE !== 16'h00A5) begin
      n_fail++;
      $display("FAIL fill_E: got pc %h ctrl %h expected 40 00a5", oPC_RegE, oCtrl_RegE);
    end
    feed(32'h48); tick();
    n_checks++;
    if (oPC_RegM !== 32'h40 || oValid_RegM !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_M: got pc %h v %b expected 40 1", oPC_RegM, oValid_RegM);
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    rst = 1; tick(); rst = 0;
    feed(32'h40); tick();
    feed(32'h44); tick();
    feed(32'h48); iStall_dec = 1; tick();
    iStall_dec = 0;
    n_checks++;
    if (oPC_RegD !== 32'h44 || oValid_RegD !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_hold_D: got pc %h v %b expected 44 1", oPC_RegD, oValid_RegD);
    end
    n_checks++;
    if (oValid_RegE !== 1'b0 || oCtrl_RegE !== '0 || oPC_RegE !== '0) begin
      n_fail++;
      $display("FAIL lu_bubble_E: got v %b ctrl %h pc %h expected 0 0 0",
               oValid_RegE, oCtrl_RegE, oPC_RegE);
    end
    n_checks++;
    if (oPC_RegM !== 32'h40 || oValid_RegM !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_adv_M: got pc %h v %b expected 40 1", oPC_RegM, oValid_RegM);
    end
    n_checks++;
    if (oBubbleCnt !== 16'd1) begin
      n_fail++;
      $display("FAIL lu_cnt: got %0d expected 1", oBubbleCnt);
    end
  endtask

  task automatic test_branch_flush();
    feed(32'h4C);
    iFlush_ifdec = 1; iFlush_decex = 1; iStall_dec = 1;
    tick();
    idle_inputs();
    n_checks++;
    if (oValid_RegD !== 1'b0 || oPC_RegD !== '0) begin
      n_fail++;
      $display("FAIL br_D: got v %b pc %h expected 0 0", oValid_RegD, oPC_RegD);
    end
    n_checks++;
    if (oValid_RegE !== 1'b0 || oBubbleCnt !== 16'd2) begin
      n_fail++;
      $display("FAIL br_E: got v %b cnt %0d expected 0 2", oValid_RegE, oBubbleCnt);
    end
  endtask

  task automatic test_deferred_flush();
    idle_inputs();
    rst = 1; tick(); rst = 0;
    feed(32'h50); tick();
    feed(32'h54); tick();
    feed(32'h58); tick();
    feed(32'h5C);
    iStall_global = 1;
    for (int c = 0; c < 3; c++) begin
      iFlush_ifdec = (c == 1);
      tick();
    end
    iFlush_ifdec = 0;
    n_checks++;
    if (oPendFlush !== 3'b001) begin
      n_fail++;
      $display("FAIL defer_pend: got %b expected 001", oPendFlush);
    end
    n_checks++;
    if (oPC_RegD !== 32'h58 || oPC_RegE !== 32'h54 || oPC_RegM !== 32'h50) begin
      n_fail++;
      $display("FAIL defer_frozen: got %h %h %h expected 58 54 50",
               oPC_RegD, oPC_RegE, oPC_RegM);
    end
    iStall_global = 0;
    tick();
    n_checks++;
    if (oValid_RegD !== 1'b0 || oPendFlush !== 3'b000) begin
      n_fail++;
      $display("FAIL defer_release: got v %b pend %b expected 0 000",
               oValid_RegD, oPendFlush);
    end
    n_checks++;
    if (oPC_RegE !== 32'h58 || oPC_RegM !== 32'h54 || oBubbleCnt !== 16'd0) begin
      n_fail++;
      $display("FAIL defer_adv: got %h %h cnt %0d expected 58 54 0",
               oPC_RegE, oPC_RegM, oBubbleCnt);
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    iStall_dec = 1;
    for (int c = 0; c < 70000; c++) tick();
    n_checks++;
    if (oBubbleCnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_reach: got %h expected ffff", oBubbleCnt);
    end
    iFlush_decex = 1;
    for (int c = 0; c < 5; c++) tick();
    idle_inputs();
    n_checks++;
    if (oBubbleCnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_hold: got %h expected ffff", oBubbleCnt);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    feed(32'h60); tick();
    feed(32'h64); tick();
    feed(32'h68); tick();
    iStall_global = 1;
    iFlush_ifdec = 1; iFlush_decex = 1; iFlush_exmem = 1;
    tick();
    iFlush_ifdec = 0; iFlush_decex = 0; iFlush_exmem = 0;
    n_checks++;
    if (oPendFlush !== 3'b111 || oValid_RegM !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: got pend %b vM %b expected 111 1",
               oPendFlush, oValid_RegM);
    end
    rst = 1; tick(); rst = 0;
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL rmid_zero: got %h expected 0", dut_vec());
    end
    iStall_global = 0;
    feed(32'h70); tick();
    n_checks++;
    if (oPC_RegD !== 32'h70 || oValid_RegD !== 1'b1 || oPendFlush !== 3'b000) begin
      n_fail++;
      $display("FAIL rmid_noflush: got pc %h v %b pend %b expected 70 1 000",
               oPC_RegD, oValid_RegD, oPendFlush);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(99) < 2);
      iStall_global = ($urandom_range(99) < 20);
      iStall_dec    = ($urandom_range(99) < 15);
      iFlush_ifdec  = ($urandom_range(99) < 10);
      iFlush_decex  = ($urandom_range(99) < 10);
      iFlush_exmem  = ($urandom_range(99) < 10);
      iPC_F    = $urandom;
      iInst_F  = $urandom;
      iValid_F = ($urandom_range(99) < 80);
      iCtrl_D  = 16'($urandom);
      iRt_D    = 5'($urandom);
      tick();
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL rand_cyc%0d: got %h expected %h", c, dut_vec(), mdl_vec());
        errs++;
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_d = '0; m_e = '0; m_m = '0; m_pend = '0; m_cnt = 0;
    test_reset();
    test_load_use();
    test_branch_flush();
    test_deferred_flush();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
